detector_sequencia: RTL

DETECTOR_SEQUENCIA -- requirements
Module: detector_sequencia

---
 rtl/detector_sequencia.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/detector_sequencia.sv
// ---------------------------------------------------------------------------
// detector_sequencia: serial pattern detector with optional per-bit mask.
//
// A WIDTH-bit pattern (and mask) is loaded, a search is started, and each
// qualified serial bit is shifted into a window. When the window is full and
// matches the pattern under the mask, encontrado pulses for one cycle and the
// saturating match counter contagem increments. Matches may overlap or not,
// selected per match by modo_sobreposto.
//
// Build option: define DETECTOR_SEQUENCIA_MASK_EN to honour mascara; without
// it mascara is ignored and every pattern bit is compared.
//
// Ports:
//   clk             clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   setar_palavra   load palavra/mascara (IDLE or ARMED only)
//   palavra         pattern to detect
//   mascara         per-bit compare enable (1 = compare)
//   modo_sobreposto 1 = overlapping matches, 0 = non-overlapping
//   start           begin search (ARMED only)
//   stop            end search, back to ARMED
//   bit_in          serial data bit
//   bit_valid       bit_in qualifier
//   encontrado      one-cycle match pulse
//   contagem        saturating match count
//   ativo           high while searching
// ---------------------------------------------------------------------------
module detector_sequencia #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             setar_palavra,
  input  logic [WIDTH-1:0] palavra,
  input  logic [WIDTH-1:0] mascara,
  input  logic             modo_sobreposto,
  input  logic             start,
  input  logic             stop,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             encontrado,
  output logic [CNT_W-1:0] contagem,
  output logic             ativo
);

  localparam int unsigned       FILL_W    = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SEARCH
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [WIDTH-1:0]   pattern_q, pattern_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               enc_q, enc_d;
  logic               ativo_q, ativo_d;

  logic [WIDTH-1:0]   shifted_c;
  logic [FILL_W-1:0]  fill_inc_c;
  logic               match_c;
  logic [WIDTH-1:0]   mask_eff;

  // Effective compare mask
`ifdef DETECTOR_SEQUENCIA_MASK_EN
  assign mask_eff = mask_q;
`else
  logic unused_mask;
  assign mask_eff    = '1;
  assign unused_mask = ^mask_q;
`endif

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    fill_d     = fill_q;
    pattern_d  = pattern_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    enc_d      = 1'b0;
    match_c    = 1'b0;
    shifted_c  = {shift_q[WIDTH-2:0], bit_in};
    fill_inc_c = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

    case (state_q)
      IDLE: begin
        if (setar_palavra) begin
          pattern_d = palavra;
          mask_d    = mascara;
          state_d   = ARMED;
        end
      end
      ARMED: begin
        // A reload wins over a same-cycle start
        if (setar_palavra) begin
          pattern_d = palavra;
          mask_d    = mascara;
        end else if (start) begin
          state_d = SEARCH;
          shift_d = '0;
          fill_d  = '0;
          cnt_d   = '0;
        end
      end
      SEARCH: begin
        if (stop) begin
          state_d = ARMED;
        end else if (bit_valid) begin
          shift_d = shifted_c;
          fill_d  = fill_inc_c;
          match_c = (fill_inc_c == FILL_FULL) &&
                    (((shifted_c ^ pattern_q) & mask_eff) == '0);
          if (match_c) begin
            enc_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            // Non-overlapping: a fresh window must be collected
            if (!modo_sobreposto) fill_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ativo_d = (state_d == SEARCH);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      fill_q    <= '0;
      pattern_q <= '0;
      mask_q    <= '1;
      cnt_q     <= '0;
      enc_q     <= 1'b0;
      ativo_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      enc_q     <= enc_d;
      ativo_q   <= ativo_d;
    end
  end

  assign encontrado = enc_q;
  assign contagem   = cnt_q;
  assign ativo      = ativo_q;

endmodule
